// File: rtl/ysyx_imm_decode_stage.sv
// ysyx_imm_decode_stage: immediate generation stage for the decode path.
// Classifies format, extends immediate, buffers results up to two deep.
module ysyx_imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;
  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic            ill;
  } ent_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       sh;
  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign sh  = (f3[1:0] == 2'b01);

  logic is_u, is_j, is_i, is_opi, is_opi32;
  logic is_s, is_b, is_sys, is_op;
  assign is_u     = (opc == 7'b0110111) | (opc == 7'b0010111);
  assign is_j     = (opc == 7'b1101111);
  assign is_i     = (opc == 7'b1100111) | (opc == 7'b0000011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_opi32 = RV64 & (opc == 7'b0011011);
  assign is_s     = (opc == 7'b0100011);
  assign is_b     = (opc == 7'b1100011);
  assign is_sys   = (opc == 7'b1110011);
  assign is_op    = (opc == 7'b0110011) |
                    (RV64 & (opc == 7'b0111011));

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] imm_z, sh5, sh6;
  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8],
                                1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21],
                                1'b0}));
  assign imm_z = XLEN'(in_inst[19:15]);
  assign sh5   = XLEN'(in_inst[24:20]);
  assign sh6   = XLEN'(in_inst[25:20]);

  ent_t d;

  // format decode and immediate select for the incoming instruction
  always_comb begin
    d.imm = '0;
    d.ty  = T_NONE;
    d.ill = 1'b0;
    unique case (1'b1)
      is_u: begin
        d.ty  = T_U;
        d.imm = imm_u;
      end
      is_j: begin
        d.ty  = T_J;
        d.imm = imm_j;
      end
      is_i: begin
        d.ty  = T_I;
        d.imm = imm_i;
      end
      is_opi: begin
        d.ty = T_I;
        if (sh) begin
          d.imm = RV64 ? sh6 : sh5;
          d.ill = ~RV64 & in_inst[25];
        end else begin
          d.imm = imm_i;
        end
      end
      is_opi32: begin
        d.ty  = T_I;
        d.imm = sh ? sh5 : imm_i;
      end
      is_s: begin
        d.ty  = T_S;
        d.imm = imm_s;
      end
      is_b: begin
        d.ty  = T_B;
        d.imm = imm_b;
      end
      is_sys: begin
        d.ty  = f3[2] ? T_Z : T_I;
        d.imm = f3[2] ? imm_z : imm_i;
      end
      is_op: begin
        d.ty = T_NONE;
      end
      default: begin
        d.ill = 1'b1;
      end
    endcase
  end

  logic [1:0] cnt;
  ent_t       e0, e1;
  logic       push, pop;

  assign out_valid   = (cnt != 2'd0);
  assign out_imm     = e0.imm;
  assign out_type    = e0.ty;
  assign out_illegal = e0.ill;
  assign pop         = out_valid & out_ready;
  assign push        = in_valid & in_ready & ~flush;

  if (SKID != 0) begin : g_skid
    assign in_ready = (cnt != 2'd2);
  end else begin : g_single
    assign in_ready = ~out_valid | out_ready;
  end

  // entry queue: e0 is the presented head, e1 absorbs a stalled input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else if (push && pop) begin
      e0 <= d;
    end else if (pop) begin
      if (cnt == 2'd2) e0 <= e1;
      cnt <= cnt - 2'd1;
    end else if (push) begin
      if (cnt == 2'd0) e0 <= d;
      else             e1 <= d;
      cnt <= cnt + 2'd1;
    end
  end

  // saturating count of illegal results delivered downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (!flush && pop && e0.ill && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_imm_decode_stage.sv
// tb_ysyx_imm_decode_stage: scoreboard bench for the immediate stage.
// Instance a: XLEN=32 SKID=1; instance b: XLEN=64 SKID=0 CNT_W=2.
module tb_ysyx_imm_decode_stage;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_flush, a_ivalid, a_iready, a_ovalid, a_oready, a_oill;
  logic [31:0] a_inst, a_oimm;
  logic [2:0]  a_otype;
  logic [15:0] a_cnt;

  logic        b_flush, b_ivalid, b_iready, b_ovalid, b_oready, b_oill;
  logic [31:0] b_inst;
  logic [63:0] b_oimm;
  logic [2:0]  b_otype;
  logic [1:0]  b_cnt;

  ysyx_imm_decode_stage #(.XLEN(32), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_ivalid), .in_ready(a_iready), .in_inst(a_inst),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_imm(a_oimm),
    .out_type(a_otype), .out_illegal(a_oill), .illegal_cnt(a_cnt)
  );

  ysyx_imm_decode_stage #(.XLEN(64), .SKID(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_ivalid), .in_ready(b_iready), .in_inst(b_inst),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_imm(b_oimm),
    .out_type(b_otype), .out_illegal(b_oill), .illegal_cnt(b_cnt)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int pass_n  = 0;
  int total_n = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", name, got, exp);
  endtask

  task automatic send(input bit b, input logic [31:0] inst,
                      input logic [63:0] imm, input logic [2:0] ty,
                      input logic ill);
    int n;
    exp_t e;
    n = 0;
    e.imm = imm;
    e.ty  = ty;
    e.ill = ill;
    if (b) begin b_ivalid = 1'b1; b_inst = inst; end
    else   begin a_ivalid = 1'b1; a_inst = inst; end
    #1;
    while (!(b ? b_iready : a_iready) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      total_n++;
      $display("FAIL send_timeout: inst %h got no in_ready", inst);
    end else begin
      if (b) qb.push_back(e);
      else   qa.push_back(e);
      @(negedge clk);
    end
    if (b) b_ivalid = 1'b0;
    else   a_ivalid = 1'b0;
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && !a_flush && a_ovalid && a_oready) begin
        if (qa.size() == 0) begin
          total_n++;
          $display("FAIL a_unexpected: got imm %h want none", a_oimm);
        end else begin
          e = qa.pop_front();
          chk("a_imm", {32'b0, a_oimm}, e.imm);
          chk("a_type", {61'b0, a_otype}, {61'b0, e.ty});
          chk("a_ill", {63'b0, a_oill}, {63'b0, e.ill});
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && !b_flush && b_ovalid && b_oready) begin
        if (qb.size() == 0) begin
          total_n++;
          $display("FAIL b_unexpected: got imm %h want none", b_oimm);
        end else begin
          e = qb.pop_front();
          chk("b_imm", b_oimm, e.imm);
          chk("b_type", {61'b0, b_otype}, {61'b0, e.ty});
          chk("b_ill", {63'b0, b_oill}, {63'b0, e.ill});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_ivalid = 0; a_oready = 0; a_inst = '0;
    b_flush = 0; b_ivalid = 0; b_oready = 0; b_inst = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_valid", {63'b0, a_ovalid}, 64'd0);
    chk("rst_imm", {32'b0, a_oimm}, 64'd0);
    chk("rst_type", {61'b0, a_otype}, 64'd0);
    chk("rst_ill", {63'b0, a_oill}, 64'd0);
    chk("rst_cnt", {48'b0, a_cnt}, 64'd0);
    chk("rst_ready", {63'b0, a_iready}, 64'd1);

    a_oready = 1'b1;
    send(0, 32'hFFF00093, 64'hFFFFFFFF, T_I, 0);
    chk("a_latency", {63'b0, a_ovalid}, 64'd1);
    send(0, 32'h12345037, 64'h12345000, T_U, 0);
    send(0, 32'h00001097, 64'h00001000, T_U, 0);
    send(0, 32'hFE000EE3, 64'hFFFFFFFC, T_B, 0);
    send(0, 32'h0080006F, 64'h00000008, T_J, 0);
    send(0, 32'h00002423, 64'h00000008, T_S, 0);
    send(0, 32'hFFC12083, 64'hFFFFFFFC, T_I, 0);
    send(0, 32'h00008067, 64'h00000000, T_I, 0);
    send(0, 32'h00509093, 64'h00000005, T_I, 0);
    send(0, 32'h41F0D093, 64'h0000001F, T_I, 0);
    send(0, 32'h02009093, 64'h00000000, T_I, 1);
    send(0, 32'h3002D073, 64'h00000005, T_Z, 0);
    send(0, 32'h34011073, 64'h00000340, T_I, 0);
    send(0, 32'h00000073, 64'h00000000, T_I, 0);
    send(0, 32'h002081B3, 64'h00000000, T_NONE, 0);
    send(0, 32'h0000001B, 64'h00000000, T_NONE, 1);
    send(0, 32'h0000007F, 64'h00000000, T_NONE, 1);
    send(0, 32'h0000007F, 64'h00000000, T_NONE, 1);
    send(0, 32'h0000007F, 64'h00000000, T_NONE, 1);
    send(0, 32'h00000000, 64'h00000000, T_NONE, 1);
    repeat (3) @(negedge clk);
    chk("a_ill_cnt", {48'b0, a_cnt}, 64'd6);

    a_oready = 1'b0;
    send(0, 32'h00100093, 64'd1, T_I, 0);
    send(0, 32'h00200113, 64'd2, T_I, 0);
    chk("a_full_ready", {63'b0, a_iready}, 64'd0);
    chk("a_hold_imm", {32'b0, a_oimm}, 64'd1);
    fork
      send(0, 32'h00300193, 64'd3, T_I, 0);
      begin
        repeat (2) @(negedge clk);
        chk("a_stall_imm", {32'b0, a_oimm}, 64'd1);
        a_oready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          chk("a_nobubble", {63'b0, a_ovalid}, 64'd1);
          @(negedge clk);
        end
      end
    join
    repeat (2) @(negedge clk);

    a_oready = 1'b0;
    send(0, 32'h0000007F, 64'd0, T_NONE, 1);
    send(0, 32'h0000007F, 64'd0, T_NONE, 1);
    qa.delete();
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    chk("a_flush_valid", {63'b0, a_ovalid}, 64'd0);
    chk("a_flush_ready", {63'b0, a_iready}, 64'd1);

    send(0, 32'h0000007F, 64'd0, T_NONE, 1);
    qa.delete();
    a_oready = 1'b1;
    a_flush  = 1'b1;
    a_ivalid = 1'b1;
    a_inst   = 32'h00500093;
    @(negedge clk);
    a_flush  = 1'b0;
    a_ivalid = 1'b0;
    chk("a_flush2_valid", {63'b0, a_ovalid}, 64'd0);
    @(negedge clk);
    chk("a_flush_nocap", {63'b0, a_ovalid}, 64'd0);
    chk("a_flush_cnt", {48'b0, a_cnt}, 64'd6);

    send(0, 32'h00500093, 64'd5, T_I, 0);
    repeat (2) @(negedge clk);

    a_oready = 1'b0;
    send(0, 32'h0000007F, 64'd0, T_NONE, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {63'b0, a_ovalid}, 64'd0);
    chk("areset_cnt", {48'b0, a_cnt}, 64'd0);
    chk("areset_imm", {32'b0, a_oimm}, 64'd0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset_ready", {63'b0, a_iready}, 64'd1);

    b_oready = 1'b1;
    send(1, 32'h80000037, 64'hFFFFFFFF80000000, T_U, 0);
    send(1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, T_I, 0);
    send(1, 32'h03F09093, 64'd63, T_I, 0);
    send(1, 32'h01F0909B, 64'd31, T_I, 0);
    send(1, 32'h0000001B, 64'd0, T_I, 0);
    send(1, 32'h0000003B, 64'd0, T_NONE, 0);
    send(1, 32'h3002D073, 64'd5, T_Z, 0);
    send(1, 32'h0000007F, 64'd0, T_NONE, 1);
    send(1, 32'h0000007F, 64'd0, T_NONE, 1);
    send(1, 32'h0000007F, 64'd0, T_NONE, 1);
    send(1, 32'h00000000, 64'd0, T_NONE, 1);
    repeat (3) @(negedge clk);
    chk("b_cnt_sat", {62'b0, b_cnt}, 64'd3);

    b_oready = 1'b0;
    send(1, 32'h00100093, 64'd1, T_I, 0);
    chk("b_stall_ready", {63'b0, b_iready}, 64'd0);
    b_oready = 1'b1;
    #1;
    chk("b_comb_ready", {63'b0, b_iready}, 64'd1);
    @(negedge clk);
    b_oready = 1'b0;
    send(1, 32'h00200093, 64'd2, T_I, 0);
    b_oready = 1'b1;
    send(1, 32'h00300093, 64'd3, T_I, 0);
    chk("b_same_cycle", {63'b0, b_ovalid}, 64'd1);
    repeat (3) @(negedge clk);

    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
